// File: rtl/aux_arb_pkg.sv
// Shared types and default sizes for the aux memory arbiter.
package aux_arb_pkg;

    localparam int unsigned AUX_DATA_WIDTH      = 16;
    localparam int unsigned AUX_ADDR_WIDTH      = 5;
    localparam int unsigned AUX_MEMORY_ELEMENTS = 10;
    localparam int unsigned AUX_MAX_WAIT        = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } cpu_state_t;

endpackage

// File: rtl/vblank_tracker.sv
// Vertical-blank flag: set on the v_sync falling edge, cleared when video starts.
// Only built when AUX_FRAME_LOCK_EN is defined.
`ifdef AUX_FRAME_LOCK_EN
module vblank_tracker (
    input  logic clock_in,
    input  logic reset_in,
    input  logic v_sync_in,
    input  logic video_on_in,
    output logic vblank_out
);

    logic r_vsync_d;
    logic r_video_d;
    logic r_vblank;

    // Registered copy starts low so a low v_sync at reset release is not taken as an edge.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_vsync_d <= 1'b0;
            r_video_d <= 1'b0;
            r_vblank  <= 1'b0;
        end else begin
            r_vsync_d <= v_sync_in;
            r_video_d <= video_on_in;
            if (video_on_in && !r_video_d) begin
                r_vblank <= 1'b0;
            end else if (r_vsync_d && !v_sync_in) begin
                r_vblank <= 1'b1;
            end
        end
    end

    assign vblank_out = r_vblank;

endmodule
`endif

// File: rtl/aux_mem_arbiter.sv
// Single-port aux RAM arbiter: display reads own the port; CPU accesses run in blanking.
// Define AUX_FRAME_LOCK_EN to restrict CPU access to vertical blanking only.
module aux_mem_arbiter
    import aux_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = AUX_DATA_WIDTH,
    parameter int unsigned AUX_ADDRESS_WIDTH = AUX_ADDR_WIDTH,
    parameter int unsigned MEMORY_ELEMENTS   = AUX_MEMORY_ELEMENTS,
    parameter int unsigned MAX_WAIT          = AUX_MAX_WAIT
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         video_on_in,
    input  logic                         v_sync_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] disp_raddress_in,
    output logic [DATA_WIDTH-1:0]        disp_data_out,
    input  logic                         cpu_req_in,
    input  logic                         cpu_we_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] cpu_address_in,
    input  logic [DATA_WIDTH-1:0]        cpu_wdata_in,
    output logic                         cpu_ack_out,
    output logic                         cpu_err_out,
    output logic [DATA_WIDTH-1:0]        cpu_rdata_out,
    output logic                         cpu_timeout_out,
    output logic                         mem_en_out,
    output logic                         mem_we_out,
    output logic [AUX_ADDRESS_WIDTH-1:0] mem_address_out,
    output logic [DATA_WIDTH-1:0]        mem_wdata_out,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_in
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    cpu_state_t            r_state;
    logic                  r_disp_rd;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] r_disp_data;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [CNT_W-1:0]      r_wait_cnt;

    logic w_window_open;
    logic w_range_err;
    logic w_cpu_own;
    logic w_disp_own;

`ifdef AUX_FRAME_LOCK_EN
    logic w_vblank;

    vblank_tracker u_vblank (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .v_sync_in   (v_sync_in),
        .video_on_in (video_on_in),
        .vblank_out  (w_vblank)
    );

    assign w_window_open = w_vblank && !video_on_in;
`else
    logic w_unused_vsync;
    assign w_unused_vsync = v_sync_in;
    assign w_window_open  = !video_on_in;
`endif

    assign w_range_err = 32'(cpu_address_in) >= MEMORY_ELEMENTS;

    // Port ownership: CPU only in a non-aborted ISSUE cycle; nobody while in reset.
    assign w_cpu_own  = !reset_in && (r_state == ISSUE) && !video_on_in;
    assign w_disp_own = !reset_in && !w_cpu_own;

    assign mem_en_out      = w_cpu_own || w_disp_own;
    assign mem_we_out      = w_cpu_own && cpu_we_in;
    assign mem_address_out = w_cpu_own  ? cpu_address_in   :
                             w_disp_own ? disp_raddress_in : '0;
    assign mem_wdata_out   = w_cpu_own ? cpu_wdata_in : '0;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state     <= IDLE;
            r_disp_rd   <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_disp_data <= '0;
            r_cpu_rdata <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_disp_rd <= w_disp_own;
            if (r_disp_rd) begin
                r_disp_data <= mem_rdata_in;
            end

            case (r_state)
                IDLE: begin
                    if (cpu_req_in) begin
                        if (w_range_err) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_window_open) begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (video_on_in) begin
                        r_state <= IDLE;
                    end else if (cpu_we_in) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_state <= RWAIT;
                    end
                end
                RWAIT: begin
                    r_cpu_rdata <= mem_rdata_in;
                    r_state     <= ACK;
                    r_ack       <= 1'b1;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Starvation counter saturates at MAX_WAIT; the timeout flag is sticky.
            if (r_ack) begin
                r_wait_cnt <= '0;
            end else if (cpu_req_in && (r_wait_cnt != CNT_W'(MAX_WAIT))) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign disp_data_out   = r_disp_data;
    assign cpu_ack_out     = r_ack;
    assign cpu_err_out     = r_err;
    assign cpu_rdata_out   = r_cpu_rdata;
    assign cpu_timeout_out = r_timeout;

endmodule

// File: tb/tb_aux_mem_arbiter.sv
// Directed bench for aux_mem_arbiter with a behavioural synchronous-read aux RAM.
module tb_aux_mem_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          video_on_in;
    logic          v_sync_in;
    logic [AW-1:0] disp_raddress_in;
    logic [DW-1:0] disp_data_out;
    logic          cpu_req_in;
    logic          cpu_we_in;
    logic [AW-1:0] cpu_address_in;
    logic [DW-1:0] cpu_wdata_in;
    logic          cpu_ack_out;
    logic          cpu_err_out;
    logic [DW-1:0] cpu_rdata_out;
    logic          cpu_timeout_out;
    logic          mem_en_out;
    logic          mem_we_out;
    logic [AW-1:0] mem_address_out;
    logic [DW-1:0] mem_wdata_out;
    logic [DW-1:0] mem_rdata_in = '0;

    logic [DW-1:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock_in = ~clock_in;

    aux_mem_arbiter #(
        .DATA_WIDTH        (DW),
        .AUX_ADDRESS_WIDTH (AW),
        .MEMORY_ELEMENTS   (10),
        .MAX_WAIT          (16)
    ) dut (
        .clock_in         (clock_in),
        .reset_in         (reset_in),
        .video_on_in      (video_on_in),
        .v_sync_in        (v_sync_in),
        .disp_raddress_in (disp_raddress_in),
        .disp_data_out    (disp_data_out),
        .cpu_req_in       (cpu_req_in),
        .cpu_we_in        (cpu_we_in),
        .cpu_address_in   (cpu_address_in),
        .cpu_wdata_in     (cpu_wdata_in),
        .cpu_ack_out      (cpu_ack_out),
        .cpu_err_out      (cpu_err_out),
        .cpu_rdata_out    (cpu_rdata_out),
        .cpu_timeout_out  (cpu_timeout_out),
        .mem_en_out       (mem_en_out),
        .mem_we_out       (mem_we_out),
        .mem_address_out  (mem_address_out),
        .mem_wdata_out    (mem_wdata_out),
        .mem_rdata_in     (mem_rdata_in)
    );

    // Single-port synchronous-read aux RAM
    always @(posedge clock_in) begin
        if (mem_en_out) begin
            if (mem_we_out) mem[mem_address_out] <= mem_wdata_out;
            else            mem_rdata_in <= mem[mem_address_out];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        cpu_req_in     = req;
        cpu_we_in      = we;
        cpu_address_in = addr;
        cpu_wdata_in   = wdata;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 | 16'(i);
        mem[3] = 16'h0003;

        reset_in         = 1'b1;
        video_on_in      = 1'b1;
        v_sync_in        = 1'b1;
        disp_raddress_in = '0;
        cpu_drive(1'b0, 1'b0, '0, '0);
        tick(2);

        check_eq("rst_ack",     32'(cpu_ack_out),     'h0);
        check_eq("rst_err",     32'(cpu_err_out),     'h0);
        check_eq("rst_rdata",   32'(cpu_rdata_out),   'h0);
        check_eq("rst_timeout", 32'(cpu_timeout_out), 'h0);
        check_eq("rst_disp",    32'(disp_data_out),   'h0);
        check_eq("rst_mem_en",  32'(mem_en_out),      'h0);

        reset_in = 1'b0;
        #1;
        check_eq("disp_own_en",   32'(mem_en_out),      'h1);
        check_eq("disp_own_addr", 32'(mem_address_out), 'h0);
        tick(2);
        check_eq("disp_first", 32'(disp_data_out), 'hA000);

`ifdef AUX_FRAME_LOCK_EN
        // Horizontal blanking alone must not grant; the v_sync fall opens the window.
        video_on_in = 1'b0;
        cpu_drive(1'b1, 1'b1, 5'h06, 16'h6666);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("lock_hblank_noack", 32'(cpu_ack_out), 'h0);
        end
        v_sync_in = 1'b0;
        tick(2);
        check_eq("lock_ack_early", 32'(cpu_ack_out), 'h0);
        tick(1);
        check_eq("lock_ack",  32'(cpu_ack_out), 'h1);
        check_eq("lock_data", 32'(mem[6]),      'h6666);
        cpu_drive(1'b0, 1'b0, '0, '0);
        v_sync_in = 1'b1;
        tick(1);
`else
        // Blanking write: ack two cycles after the request
        video_on_in = 1'b0;
        cpu_drive(1'b1, 1'b1, 5'h02, 16'h07FF);
        tick(1);
        check_eq("wr_mem_we",   32'(mem_we_out),      'h1);
        check_eq("wr_mem_addr", 32'(mem_address_out), 'h02);
        check_eq("wr_mem_data", 32'(mem_wdata_out),   'h07FF);
        check_eq("wr_ack_early", 32'(cpu_ack_out),    'h0);
        tick(1);
        check_eq("wr_ack", 32'(cpu_ack_out), 'h1);
        check_eq("wr_err", 32'(cpu_err_out), 'h0);
        cpu_drive(1'b0, 1'b0, '0, '0);
        disp_raddress_in = 5'h02;
        tick(1);
        check_eq("disp_lat_t1", 32'(disp_data_out), 'hA000);
        tick(1);
        check_eq("disp_lat_t2", 32'(disp_data_out), 'h07FF);

        // Blanking read: ack three cycles after the request
        cpu_drive(1'b1, 1'b0, 5'h03, 16'h0000);
        tick(1);
        check_eq("rd_mem_en",   32'(mem_en_out),      'h1);
        check_eq("rd_mem_we",   32'(mem_we_out),      'h0);
        check_eq("rd_mem_addr", 32'(mem_address_out), 'h03);
        tick(1);
        check_eq("rd_ack_early",   32'(cpu_ack_out),     'h0);
        check_eq("rd_rwait_disp",  32'(mem_address_out), 'h02);
        tick(1);
        check_eq("rd_ack",   32'(cpu_ack_out),   'h1);
        check_eq("rd_err",   32'(cpu_err_out),   'h0);
        check_eq("rd_rdata", 32'(cpu_rdata_out), 'h0003);
        cpu_drive(1'b0, 1'b0, '0, '0);
        tick(1);
        check_eq("rd_ack_pulse", 32'(cpu_ack_out),   'h0);
        check_eq("rd_rdata_hold", 32'(cpu_rdata_out), 'h0003);

        // Abort: video returns while in ISSUE
        disp_raddress_in = 5'h05;
        cpu_drive(1'b1, 1'b1, 5'h04, 16'hBEEF);
        tick(1);
        video_on_in = 1'b1;
        #1;
        check_eq("abort_we",   32'(mem_we_out),      'h0);
        check_eq("abort_addr", 32'(mem_address_out), 'h05);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq("abort_noack", 32'(cpu_ack_out), 'h0);
        end
        check_eq("abort_mem_kept", 32'(mem[4]), 'hA004);
        video_on_in = 1'b0;
        tick(2);
        check_eq("abort_retry_ack", 32'(cpu_ack_out), 'h1);
        check_eq("abort_retry_mem", 32'(mem[4]),      'hBEEF);
        cpu_drive(1'b0, 1'b0, '0, '0);
        tick(1);

        // Out-of-range address: immediate error ack, no access
        cpu_drive(1'b1, 1'b1, 5'h0A, 16'h1234);
        #1;
        check_eq("range_no_we", 32'(mem_we_out), 'h0);
        tick(1);
        check_eq("range_ack", 32'(cpu_ack_out), 'h1);
        check_eq("range_err", 32'(cpu_err_out), 'h1);
        cpu_drive(1'b0, 1'b0, '0, '0);
        check_eq("range_mem", 32'(mem[10]), 'hA00A);
        tick(1);
        check_eq("range_err_clear", 32'(cpu_err_out), 'h0);

        // Starvation: request held through active video
        video_on_in = 1'b1;
        cpu_drive(1'b1, 1'b1, 5'h01, 16'h5555);
        tick(15);
        check_eq("starve_15", 32'(cpu_timeout_out), 'h0);
        tick(1);
        check_eq("starve_16", 32'(cpu_timeout_out), 'h1);
        video_on_in = 1'b0;
        tick(2);
        check_eq("starve_ack",       32'(cpu_ack_out),     'h1);
        check_eq("starve_sticky_ack", 32'(cpu_timeout_out), 'h1);
        cpu_drive(1'b0, 1'b0, '0, '0);
        tick(1);
        check_eq("starve_sticky", 32'(cpu_timeout_out), 'h1);
        check_eq("starve_mem",    32'(mem[1]),          'h5555);

        // Reset during an in-flight read
        cpu_drive(1'b1, 1'b0, 5'h03, 16'h0000);
        tick(1);
        reset_in = 1'b1;
        #1;
        check_eq("midrst_mem_en", 32'(mem_en_out), 'h0);
        tick(1);
        check_eq("midrst_timeout", 32'(cpu_timeout_out), 'h0);
        check_eq("midrst_ack",     32'(cpu_ack_out),     'h0);
        cpu_drive(1'b0, 1'b0, '0, '0);
        reset_in = 1'b0;
        #1;
        check_eq("midrst_disp_en",   32'(mem_en_out),      'h1);
        check_eq("midrst_disp_addr", 32'(mem_address_out), 'h05);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("midrst_noack", 32'(cpu_ack_out), 'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
